// File: rtl/debug_run_ctrl.sv
// rtl/debug_run_ctrl.sv - debug run-enable sequencer for the i281 multicycle core
// Gates the core run input for halt, free-run, cycle/instruction stepping and a PC breakpoint.
module debug_run_ctrl #(
    parameter int PC_W  = 6,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic [PC_W-1:0]  pc,
    input  logic             instr_start,
    output logic             run,
    output logic             halted,
    output logic             bp_hit,
    output logic             cmd_err,
    output logic [1:0]       halt_cause
);

    typedef enum logic [1:0] {S_HALT, S_RUN, S_CSTEP, S_ISTEP} state_t;

    localparam logic [2:0] OP_HALT       = 3'd1;
    localparam logic [2:0] OP_RUN        = 3'd2;
    localparam logic [2:0] OP_STEP_CYC   = 3'd3;
    localparam logic [2:0] OP_STEP_INSTR = 3'd4;
    localparam logic [2:0] OP_SET_BP     = 3'd5;
    localparam logic [2:0] OP_CLR_BP     = 3'd6;

    localparam logic [1:0] CAUSE_HALT = 2'd1;
    localparam logic [1:0] CAUSE_STEP = 2'd2;
    localparam logic [1:0] CAUSE_BP   = 2'd3;

    state_t           state, state_n;
    logic [CNT_W-1:0] cyc_cnt, cyc_cnt_n;
    logic [CNT_W-1:0] icnt, icnt_n;
    logic [CNT_W-1:0] target, target_n;
    logic [PC_W-1:0]  bp_addr, bp_addr_n;
    logic             bp_valid, bp_valid_n;
    logic             first_fetch, first_fetch_n;
    logic [1:0]       halt_cause_n;
    logic             bp_hit_n, cmd_err_n;

    logic             cmd_fire;
    logic [CNT_W-1:0] arg_min1;
    logic             bp_match, stop_bp, istep_done, cstep_done;

    assign cmd_ready = 1'b1;
    assign halted    = (state == S_HALT);
    assign cmd_fire  = cmd_valid;
    assign arg_min1  = (cmd_arg == '0) ? CNT_W'(1) : cmd_arg;

    // first_fetch masks the breakpoint so resuming at the breakpoint PC executes it once
    assign bp_match   = bp_valid & instr_start & (pc == bp_addr) & ~first_fetch;
    assign stop_bp    = ((state == S_RUN) || (state == S_ISTEP)) & bp_match;
    assign istep_done = (state == S_ISTEP) & instr_start & (icnt == target);
    assign cstep_done = (state == S_CSTEP) & (cyc_cnt <= CNT_W'(1));

    always_comb begin
        state_n       = state;
        cyc_cnt_n     = cyc_cnt;
        icnt_n        = icnt;
        target_n      = target;
        bp_addr_n     = bp_addr;
        bp_valid_n    = bp_valid;
        first_fetch_n = first_fetch;
        halt_cause_n  = halt_cause;
        bp_hit_n      = 1'b0;
        cmd_err_n     = 1'b0;
        run           = 1'b0;

        case (state)
            S_HALT: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_RUN: begin
                            state_n       = S_RUN;
                            first_fetch_n = 1'b1;
                        end
                        OP_STEP_CYC: begin
                            state_n       = S_CSTEP;
                            cyc_cnt_n     = arg_min1;
                            first_fetch_n = 1'b1;
                        end
                        OP_STEP_INSTR: begin
                            state_n       = S_ISTEP;
                            icnt_n        = '0;
                            target_n      = arg_min1;
                            first_fetch_n = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                // Breakpoint and instruction-step stops drop run in the fetch cycle itself
                run = ~(stop_bp | istep_done);

                if (cmd_fire && (cmd_op == OP_RUN || cmd_op == OP_STEP_CYC ||
                                 cmd_op == OP_STEP_INSTR))
                    cmd_err_n = 1'b1;

                if (run && instr_start)
                    first_fetch_n = 1'b0;

                if (state == S_CSTEP && cyc_cnt != '0)
                    cyc_cnt_n = cyc_cnt - CNT_W'(1);

                if (state == S_ISTEP && run && instr_start && icnt != {CNT_W{1'b1}})
                    icnt_n = icnt + CNT_W'(1);

                if (stop_bp) begin
                    state_n      = S_HALT;
                    halt_cause_n = CAUSE_BP;
                    bp_hit_n     = 1'b1;
                end else if (istep_done || cstep_done) begin
                    state_n      = S_HALT;
                    halt_cause_n = CAUSE_STEP;
                end else if (cmd_fire && cmd_op == OP_HALT) begin
                    state_n      = S_HALT;
                    halt_cause_n = CAUSE_HALT;
                end
            end
        endcase

        if (cmd_fire && cmd_op == OP_SET_BP) begin
            bp_addr_n  = cmd_arg[PC_W-1:0];
            bp_valid_n = 1'b1;
        end else if (cmd_fire && cmd_op == OP_CLR_BP) begin
            bp_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_HALT;
            cyc_cnt     <= '0;
            icnt        <= '0;
            target      <= '0;
            bp_addr     <= '0;
            bp_valid    <= 1'b0;
            first_fetch <= 1'b0;
            halt_cause  <= 2'd0;
            bp_hit      <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            state       <= state_n;
            cyc_cnt     <= cyc_cnt_n;
            icnt        <= icnt_n;
            target      <= target_n;
            bp_addr     <= bp_addr_n;
            bp_valid    <= bp_valid_n;
            first_fetch <= first_fetch_n;
            halt_cause  <= halt_cause_n;
            bp_hit      <= bp_hit_n;
            cmd_err     <= cmd_err_n;
        end
    end

endmodule
